// File: rtl/rgmii_tx_ddr_fmt_if.sv
// ---------------------------------------------------------------------------
// rgmii_tx_ddr_fmt_if
// GMII transmit-side byte bus between a MAC (master) and the RGMII DDR
// formatter (slave).
//
// Signals:
//   gmii_txd     [7:0]  transmit byte                  (master -> slave)
//   gmii_tx_en          transmit enable                (master -> slave)
//   gmii_tx_er          transmit error                 (master -> slave)
//   gmii_clk_en         byte-accept strobe; the byte is taken at the rising
//                       edge that ends a cycle with this high (slave -> master)
// ---------------------------------------------------------------------------
interface rgmii_tx_ddr_fmt_if;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       gmii_clk_en;

    modport master (
        output gmii_txd,
        output gmii_tx_en,
        output gmii_tx_er,
        input  gmii_clk_en
    );

    modport slave (
        input  gmii_txd,
        input  gmii_tx_en,
        input  gmii_tx_er,
        output gmii_clk_en
    );
endinterface

// File: rtl/rgmii_tx_ddr_fmt.sv
// ---------------------------------------------------------------------------
// rgmii_tx_ddr_fmt
// Converts a GMII byte stream into per-half-cycle d1/d2 pairs for the output
// DDR flops of an RGMII transmitter (TXD[3:0], TX_CTL and forwarded TXC).
// Runs from one 125 MHz clock at every link speed. In 10/100 the slow TXC is
// built with half-cycle resolution and the GMII side is throttled through
// gmii_clk_en.
//
// Build option:
//   RGMII_TX_10_100_EN  defined   -> 10/100/1000 operation selected by speed
//                       undefined -> 1000M mapping only, speed ignored
//
// Ports:
//   clk                  125 MHz transmit clock (also clocks the DDR stage)
//   rst_n                asynchronous active-low reset
//   speed      [1:0]     00 = 10M, 01 = 100M, 1x = 1000M
//   gmii                 GMII byte bus (slave modport), carries gmii_clk_en
//   txd_d1/txd_d2 [3:0]  TXD for rising / falling half of the next cycle
//   tx_ctl_d1/tx_ctl_d2  TX_CTL for rising / falling half
//   txc_d1/txc_d2        forwarded TXC for rising / falling half
// ---------------------------------------------------------------------------
module rgmii_tx_ddr_fmt (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               speed,
    rgmii_tx_ddr_fmt_if.slave        gmii,
    output logic [3:0]               txd_d1,
    output logic [3:0]               txd_d2,
    output logic                     tx_ctl_d1,
    output logic                     tx_ctl_d2,
    output logic                     txc_d1,
    output logic                     txc_d2
);

    logic [7:0] txdByte_q, txdByte_d;
    logic       enByte_q,  enByte_d;
    logic       erByte_q,  erByte_d;
    logic       clkEn_q,   clkEn_d;

    logic [3:0] txdD1_d, txdD2_d;
    logic       ctlD1_d, ctlD2_d;
    logic       txcD1_d, txcD2_d;

`ifdef RGMII_TX_10_100_EN
    logic [6:0] cnt_q, cnt_d;
    logic [1:0] spd_q, spd_d;
    logic       boundary;
    logic [6:0] halfN;
    logic [6:0] lastCnt;
    logic [6:0] phaseJ;
    logic [6:0] halfD1;
    logic [6:0] halfD2;
    logic [3:0] nibble;
`else
    logic       unusedSpeed;
    assign unusedSpeed = ^speed;
`endif

    assign gmii.gmii_clk_en = clkEn_q;

    // Next-state logic. Every output is derived from the next-state byte and
    // counter so that a byte taken at an edge shows up, phase 0, in the very
    // next cycle, and the strobe is a clean registered decode.
    always_comb begin
        txdByte_d = txdByte_q;
        enByte_d  = enByte_q;
        erByte_d  = erByte_q;
        if (clkEn_q) begin
            txdByte_d = gmii.gmii_txd;
            enByte_d  = gmii.gmii_tx_en;
            erByte_d  = gmii.gmii_tx_er;
        end

        // 1000M mapping: one byte per cycle, low nibble on the rising half
        clkEn_d = 1'b1;
        txdD1_d = txdByte_d[3:0];
        txdD2_d = txdByte_d[7:4];
        ctlD1_d = enByte_d;
        ctlD2_d = enByte_d ^ erByte_d;
        txcD1_d = 1'b1;
        txcD2_d = 1'b0;

`ifdef RGMII_TX_10_100_EN
        // While at 1000M every cycle is a byte boundary, so a speed change
        // out of 1000M (including the reset value) takes effect at once.
        boundary = clkEn_q | spd_q[1];
        spd_d    = boundary ? speed : spd_q;
        cnt_d    = boundary ? 7'd0 : cnt_q + 7'd1;

        halfN    = spd_d[0] ? 7'd5 : 7'd50;
        lastCnt  = halfN + halfN - 7'd1;
        phaseJ   = (cnt_d >= halfN) ? cnt_d - halfN : cnt_d;
        halfD1   = phaseJ + phaseJ;
        halfD2   = halfD1 + 7'd1;
        nibble   = (cnt_d < halfN) ? txdByte_d[3:0] : txdByte_d[7:4];

        if (!spd_d[1]) begin
            // 10/100: each nibble spans one full TXC period of N cycles; the
            // TXC edge may fall between the two halves of a clk cycle when N
            // is odd, so TXC and TX_CTL are decided per half-cycle.
            clkEn_d = (cnt_d == lastCnt);
            txdD1_d = nibble;
            txdD2_d = nibble;
            txcD1_d = (halfD1 < halfN);
            txcD2_d = (halfD2 < halfN);
            ctlD1_d = txcD1_d ? enByte_d : enByte_d ^ erByte_d;
            ctlD2_d = txcD2_d ? enByte_d : enByte_d ^ erByte_d;
        end
`endif
    end

    // Byte register, strobe and registered DDR outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txdByte_q <= 8'h00;
            enByte_q  <= 1'b0;
            erByte_q  <= 1'b0;
            clkEn_q   <= 1'b0;
            txd_d1    <= 4'h0;
            txd_d2    <= 4'h0;
            tx_ctl_d1 <= 1'b0;
            tx_ctl_d2 <= 1'b0;
            txc_d1    <= 1'b0;
            txc_d2    <= 1'b0;
        end else begin
            txdByte_q <= txdByte_d;
            enByte_q  <= enByte_d;
            erByte_q  <= erByte_d;
            clkEn_q   <= clkEn_d;
            txd_d1    <= txdD1_d;
            txd_d2    <= txdD2_d;
            tx_ctl_d1 <= ctlD1_d;
            tx_ctl_d2 <= ctlD2_d;
            txc_d1    <= txcD1_d;
            txc_d2    <= txcD2_d;
        end
    end

`ifdef RGMII_TX_10_100_EN
    // Slow-speed byte timing: cycle counter and boundary-latched speed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 7'd0;
            spd_q <= 2'b10;
        end else begin
            cnt_q <= cnt_d;
            spd_q <= spd_d;
        end
    end
`endif

endmodule

// File: tb/tb_rgmii_tx_ddr_fmt.sv
// ---------------------------------------------------------------------------
// tb_rgmii_tx_ddr_fmt
// Directed self-checking bench for rgmii_tx_ddr_fmt. Outputs are sampled 1 ns
// after each rising edge and compared as a packed word:
//   {txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2, txc_d1, txc_d2, gmii_clk_en}
// The 10/100 sequences are built only when RGMII_TX_10_100_EN is defined.
// ---------------------------------------------------------------------------
module tb_rgmii_tx_ddr_fmt;

    logic       clk;
    logic       rst_n;
    logic [1:0] speed;
    logic [3:0] txd_d1;
    logic [3:0] txd_d2;
    logic       tx_ctl_d1;
    logic       tx_ctl_d2;
    logic       txc_d1;
    logic       txc_d2;

    int checks = 0;
    int errors = 0;
    int strobeCycle;
    logic txcHi;
    logic [1:0] txc100 [5] = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b00};

    rgmii_tx_ddr_fmt_if gmiiIf ();

    rgmii_tx_ddr_fmt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .speed     (speed),
        .gmii      (gmiiIf.slave),
        .txd_d1    (txd_d1),
        .txd_d2    (txd_d2),
        .tx_ctl_d1 (tx_ctl_d1),
        .tx_ctl_d2 (tx_ctl_d2),
        .txc_d1    (txc_d1),
        .txc_d2    (txc_d2)
    );

    // 125 MHz clock
    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Packs one expected/observed output word
    function automatic logic [12:0] pk(input logic [3:0] d1, input logic [3:0] d2,
                                       input logic c1, input logic c2,
                                       input logic t1, input logic t2,
                                       input logic ce);
        return {d1, d2, c1, c2, t1, t2, ce};
    endfunction

    // Drives the GMII byte inputs
    task automatic applyStimulus(input logic [7:0] txd, input logic en, input logic er);
        gmiiIf.gmii_txd   = txd;
        gmiiIf.gmii_tx_en = en;
        gmiiIf.gmii_tx_er = er;
    endtask

    // Advances to 1 ns past the next rising edge
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Compares the current DUT outputs against an expected word
    task automatic checkOutput(input string tag, input logic [12:0] expected);
        logic [12:0] observed;
        observed = pk(txd_d1, txd_d2, tx_ctl_d1, tx_ctl_d2, txc_d1, txc_d2,
                      gmiiIf.gmii_clk_en);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compares a measured count against its required value
    task automatic checkCount(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0;
        speed = 2'b10;
        applyStimulus(8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // 1000M: first strobe in cycle 1, byte register still cleared
        waitCycle();
        checkOutput("gig first strobe", pk(4'h0, 4'h0, 0, 0, 1, 0, 1));

        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitCycle();
        checkOutput("gig A5", pk(4'h5, 4'hA, 1, 1, 1, 0, 1));

        applyStimulus(8'h3C, 1'b1, 1'b0);
        waitCycle();
        checkOutput("gig 3C", pk(4'hC, 4'h3, 1, 1, 1, 0, 1));

        applyStimulus(8'h00, 1'b1, 1'b1);
        waitCycle();
        checkOutput("gig error", pk(4'h0, 4'h0, 1, 0, 1, 0, 1));

        applyStimulus(8'h0F, 1'b0, 1'b1);
        waitCycle();
        checkOutput("gig carrier ext", pk(4'hF, 4'h0, 0, 1, 1, 0, 1));

`ifdef RGMII_TX_10_100_EN
        // 100M byte 0x96; 10M byte 0x81 queued during it
        applyStimulus(8'h96, 1'b1, 1'b0);
        speed = 2'b01;
        waitCycle();
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("100M 96 c%0d", i),
                        pk(i < 5 ? 4'h6 : 4'h9, i < 5 ? 4'h6 : 4'h9, 1, 1,
                           txc100[i % 5][1], txc100[i % 5][0], i == 9));
            if (i == 0) begin
                applyStimulus(8'h81, 1'b1, 1'b1);
                speed = 2'b00;
            end
            waitCycle();
        end

        // 10M byte 0x81 with en=1, er=1
        for (int i = 0; i < 100; i++) begin
            txcHi = ((i % 50) < 25);
            checkOutput($sformatf("10M 81 c%0d", i),
                        pk(i < 50 ? 4'h1 : 4'h8, i < 50 ? 4'h1 : 4'h8,
                           txcHi, txcHi, txcHi, txcHi, i == 99));
            if (i == 0) begin
                applyStimulus(8'h5A, 1'b1, 1'b0);
                speed = 2'b01;
            end
            waitCycle();
        end

        // 100M byte 0x5A; speed goes to 1000M at cnt 3
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("100M 5A c%0d", i),
                        pk(i < 5 ? 4'hA : 4'h5, i < 5 ? 4'hA : 4'h5, 1, 1,
                           txc100[i % 5][1], txc100[i % 5][0], i == 9));
            if (i == 3) begin
                applyStimulus(8'h12, 1'b1, 1'b0);
                speed = 2'b10;
            end
            waitCycle();
        end
        checkOutput("gig after switch 12", pk(4'h2, 4'h1, 1, 1, 1, 0, 1));
        applyStimulus(8'h34, 1'b1, 1'b0);
        waitCycle();
        checkOutput("gig after switch 34", pk(4'h4, 4'h3, 1, 1, 1, 0, 1));

        // 10M byte 0xFF, reset pulsed at cnt 7
        applyStimulus(8'hFF, 1'b1, 1'b0);
        speed = 2'b00;
        waitCycle();
        checkOutput("10M FF c0", pk(4'hF, 4'hF, 1, 1, 1, 1, 0));
        repeat (7) waitCycle();
        checkOutput("10M FF c7", pk(4'hF, 4'hF, 1, 1, 1, 1, 0));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid-byte reset", pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        waitCycle();
        checkOutput("10M after reset c1", pk(4'h0, 4'h0, 0, 0, 1, 1, 0));
        strobeCycle = 0;
        for (int k = 2; k <= 150; k++) begin
            waitCycle();
            if (gmiiIf.gmii_clk_en) begin
                strobeCycle = k;
                break;
            end
        end
        checkCount("10M first strobe cycle", strobeCycle, 100);
`else
        // Without 10/100 support speed has no effect
        applyStimulus(8'h96, 1'b1, 1'b0);
        speed = 2'b01;
        waitCycle();
        checkOutput("gig speed ignored 96", pk(4'h6, 4'h9, 1, 1, 1, 0, 1));
        applyStimulus(8'h81, 1'b1, 1'b1);
        speed = 2'b00;
        waitCycle();
        checkOutput("gig speed ignored 81", pk(4'h1, 4'h8, 1, 0, 1, 0, 1));
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid-stream reset", pk(4'h0, 4'h0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        waitCycle();
        checkOutput("gig after reset c1", pk(4'h0, 4'h0, 0, 0, 1, 0, 1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_ddr_fmt.md
# rgmii_tx_ddr_fmt

Transmit-side formatter that converts a GMII byte stream into the per-half-cycle DDR data pairs consumed by the output DDR flip-flop stage driving an RGMII PHY. It produces d1/d2 pairs for TXD[3:0], TX_CTL and the forwarded TXC. It runs from a single 125 MHz clock at all link speeds. For 10/100 it generates the slow TXC with half-cycle resolution and throttles the GMII side with a clock-enable strobe.

## Interface
- No parameters; per-speed behaviour is selected at run time by `speed`, and 10/100 support is selected at build time (see Configuration).
- `clk` input 1: 125 MHz transmit clock; the same clock drives the downstream DDR output stage.
- `rst_n` input 1: reset, asynchronous, active-low.
- `speed` input 2: link speed; 2'b00 = 10M, 2'b01 = 100M, 2'b1x = 1000M.
- `gmii_txd` input 8: transmit byte.
- `gmii_tx_en` input 1: GMII transmit enable.
- `gmii_tx_er` input 1: GMII transmit error.
- `gmii_clk_en` output 1: byte-accept strobe; inputs are captured at the rising edge ending a cycle in which this is 1.
- `txd_d1` output 4: TXD value for the rising half of the next cycle.
- `txd_d2` output 4: TXD value for the falling half of the next cycle.
- `tx_ctl_d1` output 1: TX_CTL value, rising half.
- `tx_ctl_d2` output 1: TX_CTL value, falling half.
- `txc_d1` output 1: forwarded TXC value, rising half.
- `txc_d2` output 1: forwarded TXC value, falling half.

## Operation
- Define N as the number of `clk` cycles per TXC period: N = 1 (1000M), 5 (100M), 50 (10M).
- Internal state:
  - byte register {txd, en, er}; reset value 0.
  - 7-bit cycle counter `cnt`, range 0..2N-1 for 10/100; reset value 0.
  - latched speed `spd_q`; reset value 2'b10.
- 1000M mode:
  - `gmii_clk_en` = 1 every cycle.
  - `txd_d1` = txd[3:0], `txd_d2` = txd[7:4].
  - `tx_ctl_d1` = en, `tx_ctl_d2` = en ^ er.
  - `txc_d1` = 1, `txc_d2` = 0.
- 10/100 mode:
  - `gmii_clk_en` = (cnt == 2N-1).
  - Nibble selection: cnt < N sends txd[3:0]; cnt >= N sends txd[7:4]. The selected nibble is driven on both `txd_d1` and `txd_d2`.
  - Let j = cnt mod N. The half-cycle indices are h = 2j (d1 side) and 2j+1 (d2 side).
  - TXC for each half = (h < N).
  - TX_CTL for each half = en when h < N, otherwise en ^ er.
- Speed change:
  - `spd_q` loads `speed` only at a byte boundary: a cycle with `gmii_clk_en` = 1, or any cycle while `spd_q` is 1000M.
  - A mid-byte change of `speed` is ignored until that boundary.
  - `cnt` returns to 0 at every boundary.
- `gmii_tx_er` while `gmii_tx_en` = 0 is passed through as carrier-extend/error encoding; no filtering is applied.

## Timing
- All outputs are registered. Reset values: `gmii_clk_en` = 0, and all d1/d2 outputs = 0.
- `gmii_clk_en` is a registered decode of the next-state counter, so it is glitch-free.
- After `rst_n` deasserts, the first `gmii_clk_en` occurs at cycle 1 (1000M), cycle 10 (100M) or cycle 100 (10M).
- Latency: a byte captured at edge E appears on the d1/d2 outputs for the cycle immediately following E, with phase j = 0 and TXC high.
- Period length:
  - 10/100: each byte occupies exactly 2N cycles.
  - 1000M: each byte occupies exactly 1 cycle.
  - No gaps occur between consecutive bytes.
- Reset asserted mid-byte: all outputs clear asynchronously and the partial byte is dropped.

## Configuration
- `RGMII_TX_10_100_EN`:
  - Defined: full 10/100/1000 behaviour as described above.
  - Undefined: `speed` is ignored, `cnt` and `spd_q` are removed, `gmii_clk_en` is a register that resets to 0 and is 1 every cycle thereafter, and only the 1000M mapping exists.

## Test plan
- 1000M, bytes 0xA5 then 0x3C with en=1, er=0 -> consecutive cycles show d1/d2 = 5/A then C/3, ctl = 1/1, txc = 1/0.
- 1000M, en=1, er=1 on byte 0x00 -> `tx_ctl_d1` = 1, `tx_ctl_d2` = 0.
- 100M, byte 0x96, en=1:
  - txc (d1,d2) over 10 cycles = 11,11,10,00,00,11,11,10,00,00.
  - txd = 6 for 5 cycles, then 9 for 5 cycles.
  - `gmii_clk_en` high only on the last cycle.
- 10M, byte 0x81, en=1, er=1:
  - txc high for 25 cycles, then low for 25 cycles, per nibble.
  - tx_ctl = 1 during the TXC-high half and 0 during the TXC-low half.
  - `gmii_clk_en` period = 100 cycles.
- `speed` switched from 100M to 1000M at cnt = 3 -> the current byte completes its 10 cycles, then `gmii_clk_en` is continuous.
- `rst_n` pulsed low at cnt = 7 in 10M -> all outputs 0 immediately; after release, the first strobe occurs at cycle 100 (speed held 10M, `spd_q` reloads at first boundary from the 1000M reset value).
